// File: rtl/mips_pc_sequencer_pkg.sv
// Shared types and default addresses for the MIPS PC sequencer.
// Holds the jump kind encoding and the reset/halt vectors.
package mips_pc_sequencer_pkg;

    typedef enum logic [1:0] {
        J_ABS = 2'd0,
        J_REG = 2'd1,
        J_REL = 2'd2
    } jump_kind_t;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [31:0] DEF_HALT_ADDR    = 32'h0000_0000;

endpackage

// File: rtl/mips_pc_sequencer_if.sv
// Decode/regfile <-> PC sequencer bundle.
// master: decode side (drives jump info), slave: the sequencer.
interface mips_pc_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic              clk_enable;
    logic              stall;
    logic              jump_valid;
    logic [1:0]        jump_kind;
    logic              jump_taken;
    logic [25:0]       imm26;
    logic [15:0]       imm16;
    logic [ADDR_W-1:0] reg_target;
    logic [ADDR_W-1:0] instr_address;
    logic [ADDR_W-1:0] link_address;
    logic              delay_pending;
    logic              active;
    logic              addr_error;

    modport master (
        output clk_enable, stall, jump_valid, jump_kind, jump_taken,
        output imm26, imm16, reg_target,
        input  instr_address, link_address, delay_pending,
        input  active, addr_error
    );

    modport slave (
        input  clk_enable, stall, jump_valid, jump_kind, jump_taken,
        input  imm26, imm16, reg_target,
        output instr_address, link_address, delay_pending,
        output active, addr_error
    );
endinterface

// File: rtl/mips_pc_sequencer_target.sv
// Combinational jump target calculation from the current PC.
// In: pc, kind, imm26, imm16, reg_target. Out: target, misaligned.
module mips_jump_target_calc
    import mips_pc_sequencer_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [1:0]        kind,
    input  logic [25:0]       imm26,
    input  logic [15:0]       imm16,
    input  logic [ADDR_W-1:0] reg_target,
    output logic [ADDR_W-1:0] target,
    output logic              misaligned
);
    logic [ADDR_W-1:0] pc4;
    logic [ADDR_W-1:0] abs_tgt;
    logic [ADDR_W-1:0] rel_off;

    always_comb begin
        pc4           = pc + ADDR_W'(4);
        // Keep the pc4 segment bits, replace the low 28 bits.
        abs_tgt       = pc4;
        abs_tgt[27:0] = {imm26, 2'b00};
        rel_off       = {{(ADDR_W-18){imm16[15]}}, imm16, 2'b00};
        target        = pc4;
        case (kind)
            J_ABS:   target = abs_tgt;
            J_REG:   target = reg_target;
            J_REL:   target = pc4 + rel_off;
            default: target = pc4;
        endcase
        misaligned = (kind == J_REG) && (reg_target[1:0] != 2'b00);
    end
endmodule

// File: rtl/mips_pc_sequencer.sv
// Program-counter sequencer: J/JR/branch resolution, delay slot, halt.
// Ports: clk, reset (sync, active-high), bus (slave side of the PC bundle).
module mips_pc_sequencer
    import mips_pc_sequencer_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEF_RESET_VECTOR),
    parameter logic [ADDR_W-1:0] HALT_ADDR    = ADDR_W'(DEF_HALT_ADDR),
    parameter int                DELAY_SLOT   = 1
) (
    input  logic                clk,
    input  logic                reset,
    mips_pc_sequencer_if.slave  bus
);
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;
    logic              pending_q, pending_d;
    logic              active_q, active_d;
    logic              err_q, err_d;

    logic [ADDR_W-1:0] pc4;
    logic [ADDR_W-1:0] target;
    logic              misaligned;
    logic              advance;
    logic              take;

    mips_jump_target_calc #(
        .ADDR_W(ADDR_W)
    ) u_calc (
        .pc         (pc_q),
        .kind       (bus.jump_kind),
        .imm26      (bus.imm26),
        .imm16      (bus.imm16),
        .reg_target (bus.reg_target),
        .target     (target),
        .misaligned (misaligned)
    );

    always_comb begin
        pc4       = pc_q + ADDR_W'(4);
        advance   = bus.clk_enable & ~bus.stall & active_q;
        // Encoding 3 is not a jump; J_ABS/J_REG are unconditional.
        take      = bus.jump_valid & (bus.jump_kind != 2'd3) &
                    (bus.jump_taken | (bus.jump_kind != J_REL));
        pc_d      = pc_q;
        tgt_d     = tgt_q;
        pending_d = pending_q;
        active_d  = active_q;
        err_d     = err_q;
        if (advance) begin
            if (DELAY_SLOT != 0 && pending_q) begin
                // Delay slot retires: any jump here is ignored.
                pc_d      = tgt_q;
                pending_d = 1'b0;
            end else if (take && misaligned) begin
                err_d    = 1'b1;
                active_d = 1'b0;
            end else if (take) begin
                if (DELAY_SLOT != 0) begin
                    pc_d      = pc4;
                    tgt_d     = target;
                    pending_d = 1'b1;
                end else begin
                    pc_d = target;
                end
            end else begin
                pc_d = pc4;
            end
            if (!(take && misaligned && !pending_q) && pc_d == HALT_ADDR)
                active_d = 1'b0;
        end
        if (DELAY_SLOT == 0)
            pending_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q      <= RESET_VECTOR;
            tgt_q     <= '0;
            pending_q <= 1'b0;
            active_q  <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            tgt_q     <= tgt_d;
            pending_q <= pending_d;
            active_q  <= active_d;
            err_q     <= err_d;
        end
    end

    assign bus.instr_address = pc_q;
    assign bus.link_address  = pc_q + ADDR_W'(DELAY_SLOT != 0 ? 8 : 4);
    assign bus.delay_pending = pending_q;
    assign bus.active        = active_q;
    assign bus.addr_error    = err_q;
endmodule

// File: tb/tb_mips_pc_sequencer.sv
// Randomised + directed bench for mips_pc_sequencer (DELAY_SLOT=1).
// Outputs are compared against a behavioural model after each edge.
module tb_mips_pc_sequencer;
    localparam logic [31:0] RV   = 32'hBFC0_0000;
    localparam logic [31:0] HALT = 32'h0000_0000;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_bad = 0;

    logic [31:0] m_pc, m_tgt;
    bit          m_pend, m_act, m_err;

    mips_pc_sequencer_if #(.ADDR_W(32)) bus ();

    mips_pc_sequencer #(
        .ADDR_W(32),
        .DELAY_SLOT(1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        logic [31:0] pc4, tg, nxt;
        bit          take;
        int          k;
        if (reset) begin
            m_pc = RV; m_tgt = 0; m_pend = 0; m_act = 1; m_err = 0;
            return;
        end
        if (!(bus.clk_enable && !bus.stall && m_act)) return;
        k   = int'(bus.jump_kind);
        pc4 = m_pc + 4;
        case (k)
            0:       tg = {pc4[31:28], bus.imm26, 2'b00};
            1:       tg = bus.reg_target;
            2:       tg = pc4 + 32'($signed(bus.imm16)) * 4;
            default: tg = pc4;
        endcase
        take = bus.jump_valid && k != 3 && (bus.jump_taken || k != 2);
        if (m_pend) begin
            nxt = m_tgt; m_pend = 0;
        end else if (take && k == 1 && bus.reg_target % 4 != 0) begin
            m_err = 1; m_act = 0;
            return;
        end else if (take) begin
            nxt = pc4; m_tgt = tg; m_pend = 1;
        end else begin
            nxt = pc4;
        end
        m_pc = nxt;
        if (nxt == HALT) m_act = 0;
    endtask

    task automatic drive(input bit jv, input logic [1:0] kind,
                         input bit tk, input logic [25:0] i26,
                         input logic [15:0] i16, input logic [31:0] rt);
        bus.jump_valid = jv;
        bus.jump_kind  = kind;
        bus.jump_taken = tk;
        bus.imm26      = i26;
        bus.imm16      = i16;
        bus.reg_target = rt;
    endtask

    task automatic idle();
        drive(0, 2'd0, 0, 26'd0, 16'd0, 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("pc",    64'(bus.instr_address), 64'(m_pc));
        chk("pend",  64'(bus.delay_pending), 64'(m_pend));
        chk("act",   64'(bus.active),        64'(m_act));
        chk("err",   64'(bus.addr_error),    64'(m_err));
        chk("link",  64'(bus.link_address),  64'(m_pc + 8));
    endtask

    task automatic do_reset();
        reset = 1; idle();
        step();
        reset = 0;
    endtask

    task automatic go_to(input logic [31:0] a);
        do_reset();
        while (bus.instr_address != a && n_vec < 20000) step();
    endtask

    initial begin
        reset = 1;
        bus.clk_enable = 1;
        bus.stall = 0;
        idle();

        // 1: reset then sequential fetch
        step();
        reset = 0;
        chk("t1_rst_pc", 64'(bus.instr_address), 64'h BFC0_0000);
        chk("t1_rst_act", 64'(bus.active), 64'd1);
        step(); chk("t1_pc1", 64'(bus.instr_address), 64'hBFC0_0004);
        step(); chk("t1_pc2", 64'(bus.instr_address), 64'hBFC0_0008);
        step(); chk("t1_pc3", 64'(bus.instr_address), 64'hBFC0_000C);
        chk("t1_act", 64'(bus.active), 64'd1);

        // 2: JR with delay slot
        step();
        chk("t2_pc", 64'(bus.instr_address), 64'hBFC0_0010);
        chk("t2_link", 64'(bus.link_address), 64'hBFC0_0018);
        drive(1, 2'd1, 0, 26'd0, 16'd0, 32'hBFC0_0100);
        step(); idle();
        chk("t2_slot", 64'(bus.instr_address), 64'hBFC0_0014);
        chk("t2_pend", 64'(bus.delay_pending), 64'd1);
        step();
        chk("t2_tgt", 64'(bus.instr_address), 64'hBFC0_0100);
        chk("t2_pend0", 64'(bus.delay_pending), 64'd0);

        // 3: branch taken / not taken
        go_to(32'hBFC0_0020);
        drive(1, 2'd2, 1, 26'd0, 16'hFFFE, 32'd0);
        step(); idle();
        chk("t3_slot", 64'(bus.instr_address), 64'hBFC0_0024);
        step();
        chk("t3_tk", 64'(bus.instr_address), 64'hBFC0_001C);
        go_to(32'hBFC0_0020);
        drive(1, 2'd2, 0, 26'd0, 16'hFFFE, 32'd0);
        step(); idle();
        chk("t3_nt1", 64'(bus.instr_address), 64'hBFC0_0024);
        step();
        chk("t3_nt2", 64'(bus.instr_address), 64'hBFC0_0028);

        // 4: jump to halt address
        drive(1, 2'd1, 0, 26'd0, 16'd0, 32'h0);
        step(); idle();
        chk("t4_act_slot", 64'(bus.active), 64'd1);
        step();
        chk("t4_pc", 64'(bus.instr_address), 64'h0);
        chk("t4_act", 64'(bus.active), 64'd0);
        step(); step();
        chk("t4_hold", 64'(bus.instr_address), 64'h0);

        // 5: misaligned register target
        do_reset();
        step();
        drive(1, 2'd1, 0, 26'd0, 16'd0, 32'hBFC0_0102);
        step(); idle();
        chk("t5_err", 64'(bus.addr_error), 64'd1);
        chk("t5_act", 64'(bus.active), 64'd0);
        chk("t5_pc", 64'(bus.instr_address), 64'hBFC0_0004);
        step();
        chk("t5_frz", 64'(bus.instr_address), 64'hBFC0_0004);
        do_reset();
        chk("t5_clr_err", 64'(bus.addr_error), 64'd0);
        chk("t5_clr_act", 64'(bus.active), 64'd1);

        // 6: stall mid-delay-slot, then reset
        drive(1, 2'd0, 0, 26'h0_1234, 16'd0, 32'd0);
        step(); idle();
        bus.stall = 1;
        for (int i = 0; i < 3; i++) step();
        chk("t6_hold", 64'(bus.instr_address), 64'hBFC0_0004);
        chk("t6_pend", 64'(bus.delay_pending), 64'd1);
        bus.stall = 0;
        do_reset();
        chk("t6_pc", 64'(bus.instr_address), 64'hBFC0_0000);
        chk("t6_pend0", 64'(bus.delay_pending), 64'd0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] rt;
            rt = {16'hBFC0, 16'($urandom)};
            if ($urandom_range(3) != 0) rt[1:0] = 2'b00;
            if ($urandom_range(40) == 0) rt = 32'h0;
            reset = (!bus.active && $urandom_range(2) == 0) ||
                    $urandom_range(60) == 0;
            bus.clk_enable = ($urandom_range(9) != 0);
            bus.stall      = ($urandom_range(6) == 0);
            drive($urandom_range(2) == 0, 2'($urandom_range(3)),
                  1'($urandom), 26'($urandom), 16'($urandom), rt);
            step();
        end
        reset = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
